// File: rtl/rv32_pkg.sv
// Shared RV32IM definitions: opcodes, ALU operation codes, immediate formats.
// Imported by the decode stage, ALU and immediate generator.
package rv32_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17,
        ALU_FWD    = 5'd18
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_U     = 3'd3,
        IMM_J     = 3'd4,
        IMM_SHAMT = 3'd5
    } imm_type_e;

    // alt selects SUB/SRA; callers gate it for the immediate forms
    function automatic alu_op_e base_op(input logic [2:0] f3,
                                        input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            3'b000: op = alt ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic alu_op_e mext_op(input logic [2:0] f3);
        return alu_op_e'(5'(ALU_MUL) + 5'(f3));
    endfunction

endpackage

// File: rtl/rv32_regs.sv
// 32x32 architectural register file: two async reads, one sync write.
// x0 is hardwired to zero; no write-to-read bypass.
module rv32_regs
    import rv32_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/rv32_decode_regfile.sv
// RV32IM decode/register stage: combinational control decoder plus the
// architectural register file fed by the MEM/WB writeback path.
module rv32_decode_regfile
    import rv32_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic [31:0]     INSTRUCTION,
    input  logic [XLEN-1:0] IN_REG,
    input  logic [4:0]      MEM_WB_INADDRESS,
    input  logic            WRITE_REG,
    output logic [XLEN-1:0] OUT1_REG,
    output logic [XLEN-1:0] OUT2_REG,
    output logic [4:0]      ALUOP,
    output logic [2:0]      MUXIMMTYPE_SELECT,
    output logic            MUXPC_SELECT,
    output logic            MUXIMM_SELECT,
    output logic            MUXJAL_SELECT,
    output logic            MUXDATAMEM_SELECT,
    output logic            WRITE_ENABLE,
    output logic            MEM_READ,
    output logic            MEM_WRITE,
    output logic            BRANCH,
    output logic            JUMP
);

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = INSTRUCTION[6:0];
    assign rd     = INSTRUCTION[11:7];
    assign funct3 = INSTRUCTION[14:12];
    assign funct7 = INSTRUCTION[31:25];

    rv32_regs u_regs (
        .clk_i    (CLK),
        .rst_ni   (RESET),
        .raddr1_i (INSTRUCTION[19:15]),
        .raddr2_i (INSTRUCTION[24:20]),
        .we_i     (WRITE_REG),
        .waddr_i  (MEM_WB_INADDRESS),
        .wdata_i  (IN_REG),
        .rdata1_o (OUT1_REG),
        .rdata2_o (OUT2_REG)
    );

    alu_op_e   alu_op;
    imm_type_e imm_type;
    logic      wr_rd;

    always_comb begin
        alu_op            = ALU_ADD;
        imm_type          = IMM_I;
        wr_rd             = 1'b0;
        MUXPC_SELECT      = 1'b0;
        MUXIMM_SELECT     = 1'b0;
        MUXJAL_SELECT     = 1'b0;
        MUXDATAMEM_SELECT = 1'b0;
        MEM_READ          = 1'b0;
        MEM_WRITE         = 1'b0;
        BRANCH            = 1'b0;
        JUMP              = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                wr_rd = 1'b1;
                if (funct7 == 7'b0000001) begin
                    alu_op = mext_op(funct3);
                end else begin
                    alu_op = base_op(funct3, funct7 == 7'b0100000);
                end
            end
            OPC_OP_IMM: begin
                wr_rd         = 1'b1;
                MUXIMM_SELECT = 1'b1;
                // only SRAI uses bit 30; ADDI with a negative imm must not SUB
                alu_op = base_op(funct3,
                                 (funct3 == 3'b101) && INSTRUCTION[30]);
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm_type = IMM_SHAMT;
                end
            end
            OPC_LOAD: begin
                wr_rd             = 1'b1;
                MUXIMM_SELECT     = 1'b1;
                MEM_READ          = 1'b1;
                MUXDATAMEM_SELECT = 1'b1;
            end
            OPC_STORE: begin
                imm_type      = IMM_S;
                MUXIMM_SELECT = 1'b1;
                MEM_WRITE     = 1'b1;
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                BRANCH   = 1'b1;
                case (funct3[2:1])
                    2'b00:   alu_op = ALU_SUB;
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OPC_JAL: begin
                imm_type      = IMM_J;
                wr_rd         = 1'b1;
                MUXPC_SELECT  = 1'b1;
                MUXIMM_SELECT = 1'b1;
                MUXJAL_SELECT = 1'b1;
                JUMP          = 1'b1;
            end
            OPC_JALR: begin
                wr_rd         = 1'b1;
                MUXIMM_SELECT = 1'b1;
                MUXJAL_SELECT = 1'b1;
                JUMP          = 1'b1;
            end
            OPC_LUI: begin
                alu_op        = ALU_FWD;
                imm_type      = IMM_U;
                wr_rd         = 1'b1;
                MUXIMM_SELECT = 1'b1;
            end
            OPC_AUIPC: begin
                imm_type      = IMM_U;
                wr_rd         = 1'b1;
                MUXPC_SELECT  = 1'b1;
                MUXIMM_SELECT = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ALUOP             = alu_op;
    assign MUXIMMTYPE_SELECT = imm_type;
    assign WRITE_ENABLE      = wr_rd && (rd != 5'd0);

endmodule

// File: tb/tb_rv32_decode_regfile.sv
// Directed bench for rv32_decode_regfile: decoder vector table plus
// hand-written register-file reset/write/read sequences.
module tb_rv32_decode_regfile;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic [31:0] IN_REG;
    logic [4:0]  MEM_WB_INADDRESS;
    logic        WRITE_REG;
    logic [31:0] OUT1_REG;
    logic [31:0] OUT2_REG;
    logic [4:0]  ALUOP;
    logic [2:0]  MUXIMMTYPE_SELECT;
    logic        MUXPC_SELECT;
    logic        MUXIMM_SELECT;
    logic        MUXJAL_SELECT;
    logic        MUXDATAMEM_SELECT;
    logic        WRITE_ENABLE;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic        BRANCH;
    logic        JUMP;

    rv32_decode_regfile dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .INSTRUCTION       (INSTRUCTION),
        .IN_REG            (IN_REG),
        .MEM_WB_INADDRESS  (MEM_WB_INADDRESS),
        .WRITE_REG         (WRITE_REG),
        .OUT1_REG          (OUT1_REG),
        .OUT2_REG          (OUT2_REG),
        .ALUOP             (ALUOP),
        .MUXIMMTYPE_SELECT (MUXIMMTYPE_SELECT),
        .MUXPC_SELECT      (MUXPC_SELECT),
        .MUXIMM_SELECT     (MUXIMM_SELECT),
        .MUXJAL_SELECT     (MUXJAL_SELECT),
        .MUXDATAMEM_SELECT (MUXDATAMEM_SELECT),
        .WRITE_ENABLE      (WRITE_ENABLE),
        .MEM_READ          (MEM_READ),
        .MEM_WRITE         (MEM_WRITE),
        .BRANCH            (BRANCH),
        .JUMP              (JUMP)
    );

    always #5 CLK = ~CLK;

    // flags packed as {pc, imm, jal, datamem, we, mem_rd, mem_wr, branch, jump}
    typedef struct {
        logic [31:0] instr;
        logic [4:0]  alu;
        logic [2:0]  immt;
        logic [8:0]  fl;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] rsel(input logic [4:0] r1,
                                         input logic [4:0] r2);
        return {7'd0, r2, r1, 3'd0, 5'd0, 7'd0};
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [31:0] ins,
                        input logic [4:0] a, input logic [2:0] t,
                        input logic [8:0] f);
        vecs[i].instr = ins;
        vecs[i].alu   = a;
        vecs[i].immt  = t;
        vecs[i].fl    = f;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    logic [8:0] act_fl;

    initial begin
        setv(0,  32'h02A58633, 5'd10, 3'd0, 9'b000010000);
        setv(1,  32'h40B50533, 5'd1,  3'd0, 9'b000010000);
        setv(2,  32'h0002A303, 5'd0,  3'd0, 9'b010111000);
        setv(3,  32'h0062A023, 5'd0,  3'd1, 9'b010000100);
        setv(4,  32'h008000EF, 5'd0,  3'd4, 9'b111010001);
        setv(5,  32'h00B50463, 5'd1,  3'd2, 9'b000000010);
        setv(6,  32'hFFFFFFFF, 5'd0,  3'd0, 9'b000000000);
        setv(7,  32'h00500093, 5'd0,  3'd0, 9'b010010000);
        setv(8,  32'h4030D093, 5'd7,  3'd5, 9'b010010000);
        setv(9,  32'h12345137, 5'd18, 3'd3, 9'b010010000);
        setv(10, 32'h00001197, 5'd0,  3'd3, 9'b110010000);
        setv(11, 32'h00008067, 5'd0,  3'd0, 9'b011000001);
        setv(12, 32'h00B54463, 5'd3,  3'd2, 9'b000000010);
        setv(13, 32'h00B56463, 5'd4,  3'd2, 9'b000000010);
        setv(14, 32'h00208033, 5'd0,  3'd0, 9'b000000000);
        setv(15, 32'h027352B3, 5'd15, 3'd0, 9'b000010000);
        setv(16, 32'h00209093, 5'd2,  3'd5, 9'b010010000);
        setv(17, 32'h4020D0B3, 5'd7,  3'd0, 9'b000010000);
        setv(18, 32'hFFF08093, 5'd0,  3'd0, 9'b010010000);

        RESET            = 1'b0;
        WRITE_REG        = 1'b0;
        IN_REG           = '0;
        MEM_WB_INADDRESS = '0;
        INSTRUCTION      = rsel(5'd1, 5'd31);
        tick();
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk32("reset_x1", OUT1_REG, 32'h0);
        chk32("reset_x31", OUT2_REG, 32'h0);

        @(negedge CLK);
        INSTRUCTION      = rsel(5'd5, 5'd5);
        IN_REG           = 32'hDEADBEEF;
        MEM_WB_INADDRESS = 5'd5;
        WRITE_REG        = 1'b1;
        #1;
        chk32("x5_old_before_edge", OUT1_REG, 32'h0);
        tick();
        chk32("x5_after_write", OUT1_REG, 32'hDEADBEEF);

        @(negedge CLK);
        INSTRUCTION      = rsel(5'd0, 5'd5);
        IN_REG           = 32'h00001234;
        MEM_WB_INADDRESS = 5'd0;
        tick();
        chk32("x0_write_ignored", OUT1_REG, 32'h0);
        chk32("x5_kept", OUT2_REG, 32'hDEADBEEF);

        @(negedge CLK);
        INSTRUCTION      = rsel(5'd7, 5'd7);
        IN_REG           = 32'h0000AAAA;
        MEM_WB_INADDRESS = 5'd7;
        WRITE_REG        = 1'b0;
        tick();
        chk32("no_write_when_disabled", OUT1_REG, 32'h0);

        @(negedge CLK);
        INSTRUCTION = rsel(5'd31, 5'd5);
        IN_REG           = 32'hFFFFFFFF;
        MEM_WB_INADDRESS = 5'd31;
        WRITE_REG        = 1'b1;
        tick();
        chk32("x31_write", OUT1_REG, 32'hFFFFFFFF);

        @(negedge CLK);
        INSTRUCTION      = rsel(5'd7, 5'd5);
        IN_REG           = 32'h0000AAAA;
        MEM_WB_INADDRESS = 5'd7;
        RESET            = 1'b0;
        tick();
        chk32("reset_beats_write", OUT1_REG, 32'h0);
        chk32("reset_clears_x5", OUT2_REG, 32'h0);

        @(negedge CLK);
        RESET  = 1'b1;
        IN_REG = 32'h00000055;
        tick();
        chk32("write_after_release", OUT1_REG, 32'h00000055);
        INSTRUCTION = rsel(5'd31, 5'd7);
        #1;
        chk32("x31_cleared", OUT1_REG, 32'h0);

        @(negedge CLK);
        WRITE_REG = 1'b0;
        for (int i = 0; i < NV; i++) begin
            INSTRUCTION = vecs[i].instr;
            #1;
            act_fl = {MUXPC_SELECT, MUXIMM_SELECT, MUXJAL_SELECT,
                      MUXDATAMEM_SELECT, WRITE_ENABLE, MEM_READ,
                      MEM_WRITE, BRANCH, JUMP};
            n_vec++;
            if (ALUOP !== vecs[i].alu || MUXIMMTYPE_SELECT !== vecs[i].immt ||
                act_fl !== vecs[i].fl) begin
                n_fail++;
                $display("FAIL dec[%0d] %08h: got alu=%0d imm=%0d fl=%b expected alu=%0d imm=%0d fl=%b",
                         i, vecs[i].instr, ALUOP, MUXIMMTYPE_SELECT, act_fl,
                         vecs[i].alu, vecs[i].immt, vecs[i].fl);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
